// File: rtl/poly_rom_loader.sv
// poly_rom_loader
//   Sequences the hps_io ioctl download stream into the Poly-Play ROM write
//   port through a 2-entry FIFO, latches the title number, and holds the game
//   core in reset until a complete ROM image has been written.
//
//   Optional feature macro: POLY_ROM_CHECKSUM_EN
//     defined   : checksum is the mod-256 sum of accepted image bytes
//     undefined : checksum is tied to 8'h00
//
// Ports
//   clk_sys        in   1   system clock, rising edge
//   reset_n        in   1   synchronous active-low reset
//   ioctl_download in   1   hps_io transfer in progress
//   ioctl_wr       in   1   byte strobe
//   ioctl_addr     in   25  byte address
//   ioctl_dout     in   8   byte data
//   ioctl_index    in   8   file/slot index
//   ioctl_wait     out  1   back-pressure (FIFO full)
//   rom_ready      in   1   ROM port can take a write this cycle
//   rom_we         out  1   ROM write strobe
//   rom_addr       out  16  ROM write address
//   rom_data       out  8   ROM write data
//   cpu_hold       out  1   core reset request, active high
//   load_done      out  1   image loaded, core released
//   load_err       out  1   a byte was dropped during this download
//   tno            out  8   title number
//   checksum       out  8   running byte sum of the image
module poly_rom_loader #(
   parameter int unsigned ROM_BYTES   = 49152,
   parameter logic [7:0]  ROM_INDEX   = 8'd0,
   parameter logic [7:0]  TNO_INDEX   = 8'd1,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        ioctl_wait,
   input  logic        rom_ready,
   output logic        rom_we,
   output logic [15:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err,
   output logic [7:0]  tno,
   output logic [7:0]  checksum
);

   localparam logic [24:0] LP_ROM_BYTES = 25'(ROM_BYTES);
   localparam logic [7:0]  LP_HOLD_INIT = 8'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_HOLD,
      ST_RUN
   } state_t;

   state_t      r_state;
   logic [7:0]  r_hold_cnt;
   logic        r_cpu_hold;
   logic        r_load_done;
   logic        r_load_err;
   logic [7:0]  r_tno;

   logic [1:0]  r_count;
   logic [23:0] r_e0;
   logic [23:0] r_e1;
   logic        r_rom_we;
   logic [15:0] r_rom_addr;
   logic [7:0]  r_rom_data;

   logic        w_rom_idx;
   logic        w_in_range;
   logic        w_rom_wr;
   logic        w_push_try;
   logic        w_pop;
   logic        w_push;
   logic        w_enter_load;
   logic [23:0] w_in;
   logic [23:0] w_head;

   assign w_rom_idx    = (ioctl_index == ROM_INDEX);
   assign w_in_range   = (ioctl_addr < LP_ROM_BYTES);
   assign w_rom_wr     = ioctl_wr & w_rom_idx & (r_state == ST_LOAD);
   assign w_push_try   = w_rom_wr & w_in_range;
   // An empty FIFO forwards the incoming byte straight to the ROM port,
   // so a write can appear the cycle after its strobe.
   assign w_pop        = rom_ready & ((r_count != 2'd0) | w_push_try);
   assign w_push       = w_push_try & ((r_count != 2'd2) | w_pop);
   assign w_enter_load = ioctl_download & w_rom_idx & (r_state != ST_LOAD);
   assign w_in         = {ioctl_addr[15:0], ioctl_dout};
   assign w_head       = (r_count == 2'd0) ? w_in : r_e0;

   assign ioctl_wait = (r_count == 2'd2);
   assign rom_we     = r_rom_we;
   assign rom_addr   = r_rom_addr;
   assign rom_data   = r_rom_data;
   assign cpu_hold   = r_cpu_hold;
   assign load_done  = r_load_done;
   assign load_err   = r_load_err;
   assign tno        = r_tno;

`ifdef POLY_ROM_CHECKSUM_EN
   logic [7:0] r_sum;
   assign checksum = r_sum;
`else
   assign checksum = 8'h00;
`endif

   // FIFO and ROM write port
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_count    <= '0;
         r_e0       <= '0;
         r_e1       <= '0;
         r_rom_we   <= 1'b0;
         r_rom_addr <= '0;
         r_rom_data <= '0;
      end else begin
         r_rom_we <= w_pop;
         if (w_pop) begin
            {r_rom_addr, r_rom_data} <= w_head;
         end
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_e0 <= w_in;
               else                 r_e1 <= w_in;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_e0    <= r_e1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // count 0 is a pure bypass: nothing is stored
               if (r_count == 2'd1) begin
                  r_e0 <= w_in;
               end else if (r_count == 2'd2) begin
                  r_e0 <= r_e1;
                  r_e1 <= w_in;
               end
            end
            default: ;
         endcase
      end
   end

   // Load sequencer with registered core-control outputs
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_hold_cnt  <= '0;
         r_cpu_hold  <= 1'b1;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
         r_tno       <= '0;
`ifdef POLY_ROM_CHECKSUM_EN
         r_sum       <= '0;
`endif
      end else begin
         if (ioctl_wr && (ioctl_index == TNO_INDEX)) begin
            r_tno <= ioctl_dout;
         end
         if (w_enter_load) begin
            r_state     <= ST_LOAD;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef POLY_ROM_CHECKSUM_EN
            r_sum       <= '0;
`endif
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_cpu_hold <= 1'b1;
               end
               ST_LOAD: begin
                  // covers both out-of-range and FIFO-overrun drops
                  if (w_rom_wr && !w_push) begin
                     r_load_err <= 1'b1;
                  end
`ifdef POLY_ROM_CHECKSUM_EN
                  if (w_push) begin
                     r_sum <= r_sum + ioctl_dout;
                  end
`endif
                  if (!ioctl_download) begin
                     r_state <= ST_FLUSH;
                  end
               end
               ST_FLUSH: begin
                  if (r_count == 2'd0) begin
                     r_state    <= ST_HOLD;
                     r_hold_cnt <= LP_HOLD_INIT;
                  end
               end
               ST_HOLD: begin
                  if (r_hold_cnt == 8'd0) begin
                     r_state     <= ST_RUN;
                     r_cpu_hold  <= 1'b0;
                     r_load_done <= 1'b1;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - 8'd1;
                  end
               end
               ST_RUN: ;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_poly_rom_loader.sv
module tb_poly_rom_loader;

   localparam int unsigned HOLD = 8;
   localparam int unsigned ROMB = 49152;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wait;
   logic        rom_ready = 1'b1;
   logic        rom_we;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [7:0]  tno;
   logic [7:0]  checksum;

   always #5 clk_sys = ~clk_sys;

   poly_rom_loader #(
      .ROM_BYTES(ROMB),
      .ROM_INDEX(8'd0),
      .TNO_INDEX(8'd1),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .ioctl_index(ioctl_index),
      .ioctl_wait(ioctl_wait),
      .rom_ready(rom_ready),
      .rom_we(rom_we),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .cpu_hold(cpu_hold),
      .load_done(load_done),
      .load_err(load_err),
      .tno(tno),
      .checksum(checksum)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  m_sum = '0;
   logic        m_err = 1'b0;
   logic [7:0]  m_tno = '0;
   bit          rnd_ready = 1'b0;
   int unsigned cyc = 0;
   int unsigned last_we_cyc = 0;
   logic        ready_q = 1'b0;

   always @(posedge clk_sys) begin
      cyc     <= cyc + 1;
      ready_q <= rom_ready;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_sum();
`ifdef POLY_ROM_CHECKSUM_EN
      return m_sum;
`else
      return 8'h00;
`endif
   endfunction

   task automatic tick();
      @(negedge clk_sys);
      if (rnd_ready) rom_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic start_dl();
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      m_err = 1'b0;
      m_sum = 8'h00;
      tick();
   endtask

   // drop=1: the bench knows the FIFO is full and stalled, so the byte is lost
   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit obey_wait, input bit drop);
      int unsigned guard = 0;
      if (obey_wait) begin
         while (ioctl_wait === 1'b1 && guard < 200) begin
            tick();
            guard++;
         end
         if (guard >= 200) check("wait_timeout", 32'(ioctl_wait), 32'd0);
      end
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_index = 8'd0;
      ioctl_wr    = 1'b1;
      if (a >= 25'(ROMB) || drop) begin
         m_err = 1'b1;
      end else begin
         exp_q.push_back({a[15:0], d});
         m_sum = m_sum + d;
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_release();
      int unsigned guard = 0;
      while (cpu_hold !== 1'b0 && guard < 400) begin
         tick();
         guard++;
      end
      if (guard >= 400) check("release_timeout", 32'(cpu_hold), 32'd0);
   endtask

   task automatic check_image(input string tag);
      check({tag, "_load_done"}, 32'(load_done), 32'd1);
      check({tag, "_load_err"}, 32'(load_err), 32'(m_err));
      check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum()));
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rom_we"}, 32'(rom_we), 32'd0);
      check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      check({tag, "_rom_data"}, 32'(rom_data), 32'd0);
      check({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "_load_done"}, 32'(load_done), 32'd0);
      check({tag, "_load_err"}, 32'(load_err), 32'd0);
      check({tag, "_tno"}, 32'(tno), 32'd0);
      check({tag, "_checksum"}, 32'(checksum), 32'd0);
   endtask

   initial begin
      logic [7:0]  d;
      logic [24:0] a;
      bit          hold_ok;
      int unsigned delta;

      fork
         // scoreboard monitor
         forever begin
            @(negedge clk_sys);
            if (rom_we === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_rom_we: got addr %0h data %0h expected no write", rom_addr, rom_data);
               end else begin
                  check("rom_write", 32'({rom_addr, rom_data}), 32'(exp_q.pop_front()));
                  check("rom_ready_at_we", 32'(ready_q), 32'd1);
                  last_we_cyc = cyc;
               end
            end
         end
         begin
            #2000000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
         end
      join_none

      // reset state
      tick(); tick();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      tick();

      // test 1: 4-byte image, ROM always ready
      rom_ready = 1'b1;
      start_dl();
      send_byte(25'd0, 8'hA5, 1'b1, 1'b0);
      send_byte(25'd1, 8'h5A, 1'b1, 1'b0);
      send_byte(25'd2, 8'hFF, 1'b1, 1'b0);
      send_byte(25'd3, 8'h01, 1'b1, 1'b0);
      ioctl_download = 1'b0;
      wait_release();
      // LOAD->FLUSH and FLUSH->HOLD each take a cycle, then HOLD lasts HOLD cycles
      delta = cyc - last_we_cyc;
      check("t1_hold_cycles", delta, 32'(HOLD + 2));
      check_image("t1");

      // test 4: title number during RUN
      ioctl_index = 8'd1;
      ioctl_dout  = 8'h07;
      ioctl_wr    = 1'b1;
      m_tno       = 8'h07;
      tick();
      ioctl_wr    = 1'b0;
      ioctl_index = 8'd0;
      check("t4_tno", 32'(tno), 32'(m_tno));
      tick();
      check("t4_cpu_hold", 32'(cpu_hold), 32'd0);

      // test 2: stalled ROM, three back-to-back strobes ignoring wait
      start_dl();
      rom_ready = 1'b0;
      send_byte(25'h10, 8'(32'($urandom)), 1'b0, 1'b0);
      send_byte(25'h11, 8'(32'($urandom)), 1'b0, 1'b0);
      check("t2_wait_full", 32'(ioctl_wait), 32'd1);
      send_byte(25'h12, 8'(32'($urandom)), 1'b0, 1'b1);
      check("t2_overrun_err", 32'(load_err), 32'd1);
      rom_ready = 1'b1;
      repeat (4) tick();
      check("t2_drained", 32'(exp_q.size()), 32'd0);
      check("t2_wait_clear", 32'(ioctl_wait), 32'd0);
      ioctl_download = 1'b0;
      wait_release();
      check_image("t2");

      // test 3: byte at the first out-of-range address
      start_dl();
      check("t3_err_cleared", 32'(load_err), 32'd0);
      send_byte(25'(ROMB), 8'h3C, 1'b1, 1'b0);
      check("t3_range_err", 32'(load_err), 32'd1);
      check("t3_tno", 32'(tno), 32'(m_tno));
      repeat (3) tick();
      ioctl_download = 1'b0;
      wait_release();
      check_image("t3");

      // randomized images with random ROM stalls
      for (int r = 0; r < 3; r++) begin
         start_dl();
         rnd_ready = 1'b1;
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) a = 25'($urandom_range(ROMB, 32'h1FF_FFFF));
            else                           a = 25'($urandom_range(0, ROMB - 1));
            d = 8'(32'($urandom));
            send_byte(a, d, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
         end
         ioctl_download = 1'b0;
         rnd_ready = 1'b0;
         rom_ready = 1'b1;
         wait_release();
         check_image("rnd");
      end

      // test 5: new image arrives while the first is in HOLD
      start_dl();
      send_byte(25'h100, 8'h11, 1'b1, 1'b0);
      send_byte(25'h101, 8'h22, 1'b1, 1'b0);
      ioctl_download = 1'b0;
      repeat (3) tick();
      check("t5_in_hold", 32'(cpu_hold), 32'd1);
      start_dl();
      hold_ok = 1'b1;
      for (int i = 0; i < int'(2 * HOLD); i++) begin
         if (cpu_hold !== 1'b1 || load_done !== 1'b0) hold_ok = 1'b0;
         tick();
      end
      send_byte(25'h200, 8'h33, 1'b1, 1'b0);
      send_byte(25'h201, 8'h44, 1'b1, 1'b0);
      if (cpu_hold !== 1'b1 || load_done !== 1'b0) hold_ok = 1'b0;
      check("t5_held_during_reload", 32'(hold_ok), 32'd1);
      ioctl_download = 1'b0;
      wait_release();
      check_image("t5");

      // test 6: reset mid-LOAD with one byte queued
      start_dl();
      rom_ready = 1'b0;
      send_byte(25'h20, 8'h5E, 1'b1, 1'b0);
      tick();
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      exp_q.delete();
      tick();
      reset_n = 1'b1;
      check_reset_outputs("t6");
      rom_ready = 1'b1;
      repeat (6) tick();
      check("t6_still_held", 32'(cpu_hold), 32'd1);
      check("t6_not_done", 32'(load_done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
